// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin arbiter and sequencer for one shared memory.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_i, we_i               per-port request and write enable (bit p = port p)
//   addr0_i/addr1_i           per-port address
//   wdata0_i/wdata1_i         per-port write data
//   gnt_o, rvalid_o           one-cycle grant / read-data-valid pulses, one-hot or zero
//   rdata_o                   captured read data, shared by both ports
//   busy_o                    high whenever the sequencer is not idle
//   mem_addr_o, mem_wdata_o   memory address and write data, held for the whole transfer
//   mem_we_o                  memory write strobe
//   mem_rdata_i               memory read data, valid RD_LAT cycles after the address cycle
module mem_port_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [WIDTH-1:0]  wdata0_i,
    input  logic [WIDTH-1:0]  wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [WIDTH-1:0]  rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    output logic              mem_we_o,
    input  logic [WIDTH-1:0]  mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, state_n;
    logic       last, win, we_q;
    logic [3:0] cnt;
    logic       arb, pick;

    assign arb  = (state == IDLE) || (state == RESP);
    // On a tie the port that was not granted last wins.
    assign pick = (req_i == 2'b11) ? ~last : req_i[1];

    always_comb begin
        state_n = state;
        state_n = arb              ? (|req_i ? ISSUE : IDLE) :
                  (state == ISSUE) ? (we_q ? IDLE : WAIT) :
                  (cnt == 4'd1)    ? RESP : WAIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            win         <= 1'b0;
            we_q        <= 1'b0;
            cnt         <= 4'd0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
        end else begin
            state <= state_n;
            if (arb && |req_i) begin
                win         <= pick;
                last        <= pick;
                we_q        <= pick ? we_i[1] : we_i[0];
                mem_addr_o  <= pick ? addr1_i : addr0_i;
                mem_wdata_o <= pick ? wdata1_i : wdata0_i;
            end
            if (state == ISSUE && !we_q)
                cnt <= 4'(RD_LAT);
            else if (state == WAIT)
                cnt <= cnt - 4'd1;
            if (state == WAIT && cnt == 4'd1)
                rdata_o <= mem_rdata_i;
        end
    end

    // All handshake outputs decode from registered state only.
    assign gnt_o    = (state == ISSUE) ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign rvalid_o = (state == RESP)  ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign mem_we_o = (state == ISSUE) && we_q;
    assign busy_o   = (state != IDLE);
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer for the single shared instruction/data memory of the multicycle core. Port 0 is the core's memory interface (fetch and load/store); port 1 is the program loader/debug port. The block serialises requests with round-robin priority. It drives the memory's one address/write port, holds the address stable for the memory's fixed read latency, and returns read data to the port that requested it.

## Interface
- WIDTH, 32, data width
- ADDR_W, 32, address width
- RD_LAT, 1, memory read latency in cycles; legal range 1..8

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_i  in  2  per-port request; bit p = port p
- we_i  in  2  per-port write enable, qualified by req_i
- addr0_i, addr1_i  in  ADDR_W  per-port address
- wdata0_i, wdata1_i  in  WIDTH  per-port write data
- gnt_o  out  2  one-cycle grant pulse, one-hot or zero
- rvalid_o  out  2  one-cycle read-data-valid pulse, one-hot or zero
- rdata_o  out  WIDTH  read data, shared by both ports, valid while rvalid_o != 0
- busy_o  out  1  high in any state other than IDLE
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  WIDTH  memory write data
- mem_we_o  out  1  memory write strobe
- mem_rdata_i  in  WIDTH  memory read data, valid RD_LAT cycles after the address cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Arbitration happens only in IDLE and RESP. The block samples req_i in those states; requests in other states are ignored until the next arbitration cycle.
- Winner selection:
  - Exactly one request: that port wins.
  - Both requesting: the port not granted last wins.
  - A 1-bit last-grant pointer updates on every grant. Reset value is 1, so port 0 wins the first tie.
- On arbitration with a winner, at the clock edge:
  - The winner's addr, wdata and we are latched into mem_addr_o, mem_wdata_o and an internal we flag.
  - The winner index is latched.
  - The FSM goes to ISSUE.
- With no request, the FSM goes to or stays in IDLE.
- ISSUE:
  - gnt_o[winner] = 1.
  - mem_we_o = latched we; mem_we_o is high only in ISSUE.
  - Write: next state IDLE.
  - Read: next state WAIT; load the down-counter with RD_LAT.
- WAIT:
  - mem_addr_o is held.
  - The counter decrements each cycle.
  - In the cycle the counter equals 1, mem_rdata_i is captured into rdata_o at the edge and the FSM goes to RESP.
- RESP:
  - rvalid_o[winner] = 1.
  - Arbitrates like IDLE, so back-to-back transfers lose no extra cycle.
- rdata_o holds its last captured value until the next capture.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Deassert or change them at the edge ending the gnt cycle.
  - A request withdrawn before it is sampled has no effect.
- gnt_o and rvalid_o are never both nonzero in one cycle.

## Timing
- Reset (async, immediate): state IDLE, gnt_o = 0, rvalid_o = 0, busy_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, rdata_o = 0, last pointer = 1, counter = 0.
- Reset mid-transfer aborts the transfer: no gnt_o or rvalid_o pulse follows and no memory write occurs after reset.
- Write, req sampled in cycle t: gnt_o and mem_we_o high in t+1; next arbitration in t+2. Sustained throughput is 1 write per 2 cycles.
- Read, req sampled in cycle t:
  - gnt_o in t+1.
  - WAIT spans t+2 .. t+1+RD_LAT; capture at the end of t+1+RD_LAT.
  - rvalid_o in t+2+RD_LAT.
  - A new request sampled in the RESP cycle is granted in t+3+RD_LAT.
- All outputs are registered or decoded from the state register only; there is no combinational path from req_i to gnt_o.

## Test plan
- Reset: rst pulsed mid-cycle with req_i = 2'b11 -> all outputs 0 immediately. After release, the first tie grants port 0.
- Single write: port 0 req with we = 1, addr 0x10, wdata 0xDEADBEEF, sampled in cycle 1 -> gnt_o = 01, mem_we_o = 1, mem_addr_o = 0x10, mem_wdata_o = 0xDEADBEEF in cycle 2 only; busy_o = 0 in cycle 3.
- Read, RD_LAT = 3, memory model returns 0x12345678 for addr 0x40: port 1 read sampled in cycle 1 -> gnt_o = 10 in cycle 2; mem_addr_o = 0x40 held through cycles 2..5; rvalid_o = 10 with rdata_o = 0x12345678 in cycle 6.
- Contention: both ports issue continuous writes -> grants alternate 01, 10, 01, 10 on every second cycle, starting with port 0 after reset.
- Back-to-back reads, RD_LAT = 1: port 0 requests a new read in its RESP cycle -> next gnt_o = 01 in the cycle after RESP; no idle gap.
- Reset in WAIT: rst asserted during the second WAIT cycle of an RD_LAT = 4 read -> no rvalid_o pulse ever. A following port 1 write completes normally with gnt_o = 10 one cycle after sampling.
